// File: rtl/pl_fetch_pc.sv
// pl_fetch_pc: instruction fetch program-counter stage.
// Holds the PC, drives the instruction memory address, and reports which
// cycles carry a real fetch. Branch redirects from EX win over stalls.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
// Without it, opcode 5'b11111 is fetched like any other instruction.
module pl_fetch_pc #(
  parameter int                      PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  input  logic                    stall_IF,
  input  logic [15:0]             instr_mem_out,
  output logic [PROG_CTR_WID-1:0] instr_mem_addr,
  output logic [PROG_CTR_WID-1:0] fetch_pc_IF,
  output logic                    fetch_valid,
  output logic                    halted,
  output logic                    pc_wrap,
  output logic [15:0]             fetch_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PROG_CTR_WID-1:0] PC_ONE = {{(PROG_CTR_WID-1){1'b0}}, 1'b1};

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [PROG_CTR_WID-1:0] pc;
  logic [PROG_CTR_WID-1:0] pc_nxt;
  logic [PROG_CTR_WID-1:0] pc_inc;
  logic                    accept;
  logic                    halt_op;
  logic                    wrap_now;

  assign pc_inc         = pc + PC_ONE;
  assign instr_mem_addr = pc;

  // A fetch is real only while running with no stall and no redirect.
  assign accept      = (state == ST_RUN) && !stall_IF && !branch_taken_EX;
  assign fetch_valid = accept;

  // The PC wraps only when a real increment rolls over from all-ones.
  assign wrap_now = accept && !halt_op && (&pc);

`ifdef FETCH_HALT_DETECT_EN
  logic unused_instr_low;
  assign unused_instr_low = ^instr_mem_out[10:0];
  assign halt_op          = accept && (instr_mem_out[15:11] == 5'b11111);
`else
  logic unused_instr_all;
  assign unused_instr_all = ^instr_mem_out;
  assign halt_op          = 1'b0;
`endif

  // Next state and next PC; BOOT ignores redirects so reset always starts clean.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken_EX) begin
          pc_nxt = branch_target_EX;
        end else if (!stall_IF) begin
          if (halt_op) begin
            state_nxt = ST_HALT;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      ST_HALT: begin
        if (branch_taken_EX) begin
          pc_nxt    = branch_target_EX;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      state <= ST_BOOT;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  // Remember the address of the instruction handed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_IF <= RESET_VECTOR;
    end else if (accept) begin
      fetch_pc_IF <= pc;
    end
  end

  // Saturating count of accepted fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 16'h0000;
    end else if (accept && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

  // Sticky wrap flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_wrap <= 1'b0;
    end else if (wrap_now) begin
      pc_wrap <= 1'b1;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  // Registered halt indicator tracks entry to and exit from HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else begin
      halted <= (state_nxt == ST_HALT);
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule
